// File: rtl/prv664_cache_ret_pkg.sv
// Shared types for the cache return path: one buffered return beat and its field widths.
package prv664_cache_ret_pkg;

    localparam int XLEN         = 64;
    localparam int CACHE_USER_W = 4;
    localparam int ID_W         = 8;
    localparam int ERR_W        = 6;

    typedef struct packed {
        logic [2*XLEN-1:0]       rdata;
        logic [ID_W-1:0]         id;
        logic [CACHE_USER_W-1:0] user;
        logic [ERR_W-1:0]        error;
        logic                    mmio;
    } cache_ret_beat_t;

endpackage

// File: rtl/cache_return_arbiter_if.sv
// Source-side push ports and the registered cache return channel of the arbiter.
interface cache_return_arbiter_if
    import prv664_cache_ret_pkg::*;
#(
    parameter int N_PORT = 4
);
    localparam int SRC_W = $clog2(N_PORT);

    logic [N_PORT-1:0]                   src_valid_i;
    logic [N_PORT-1:0]                   src_ready_o;
    logic [N_PORT-1:0][2*XLEN-1:0]       src_rdata_i;
    logic [N_PORT-1:0][ID_W-1:0]         src_id_i;
    logic [N_PORT-1:0][CACHE_USER_W-1:0] src_user_i;
    logic [N_PORT-1:0][ERR_W-1:0]        src_error_i;
    logic [N_PORT-1:0]                   src_mmio_i;

    logic [2*XLEN-1:0]       ret_rdata_o;
    logic [ID_W-1:0]         ret_id_o;
    logic [CACHE_USER_W-1:0] ret_user_o;
    logic                    ret_valid_o;
    logic [ERR_W-1:0]        ret_error_o;
    logic                    ret_mmio_o;
    logic [SRC_W-1:0]        ret_src_o;

    modport master (
        input  src_valid_i, src_rdata_i, src_id_i, src_user_i, src_error_i, src_mmio_i,
        output src_ready_o,
        output ret_rdata_o, ret_id_o, ret_user_o, ret_valid_o, ret_error_o, ret_mmio_o, ret_src_o
    );

    modport slave (
        output src_valid_i, src_rdata_i, src_id_i, src_user_i, src_error_i, src_mmio_i,
        input  src_ready_o,
        input  ret_rdata_o, ret_id_o, ret_user_o, ret_valid_o, ret_error_o, ret_mmio_o, ret_src_o
    );

endinterface

// File: rtl/cache_ret_fifo.sv
// Small synchronous FIFO of return beats; head is readable combinationally so a pop can load it the same edge.
module cache_ret_fifo
    import prv664_cache_ret_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            push,
    input  cache_ret_beat_t push_data,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output cache_ret_beat_t head
);
    localparam int PTR_W = $clog2(DEPTH);

    cache_ret_beat_t  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even when popping: ready must come from registered state only.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/cache_return_arbiter.sv
// Per-source FIFOs feeding one registered cache return channel through a rotating-priority grant.
module cache_return_arbiter
    import prv664_cache_ret_pkg::*;
#(
    parameter int N_PORT     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    cache_return_arbiter_if.master bus
);
    localparam int SRC_W = $clog2(N_PORT);

    cache_ret_beat_t   in_beat [N_PORT];
    cache_ret_beat_t   head    [N_PORT];
    logic [N_PORT-1:0] full;
    logic [N_PORT-1:0] empty;
    logic [N_PORT-1:0] pop;

    logic [SRC_W-1:0]  last_reg;
    logic [SRC_W-1:0]  grant_idx;
    logic              grant_valid;

    cache_ret_beat_t   ret_beat_reg;
    logic              ret_valid_reg;
    logic [SRC_W-1:0]  ret_src_reg;

    assign bus.src_ready_o = ~full;

    generate
        for (genvar gi = 0; gi < N_PORT; gi++) begin : g_port
            assign in_beat[gi] = {bus.src_rdata_i[gi], bus.src_id_i[gi], bus.src_user_i[gi],
                                  bus.src_error_i[gi], bus.src_mmio_i[gi]};
            assign pop[gi]     = grant_valid && (grant_idx == SRC_W'(gi));

            cache_ret_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
                .clk       (clk_i),
                .srst      (srst_i),
                .push      (bus.src_valid_i[gi]),
                .push_data (in_beat[gi]),
                .pop       (pop[gi]),
                .full      (full[gi]),
                .empty     (empty[gi]),
                .head      (head[gi])
            );
        end
    endgenerate

    // Scan starts just after the last winner and wraps, so the most recent winner has lowest priority.
    always_comb begin
        logic [SRC_W-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_PORT; k++) begin
            cand = SRC_W'((int'(last_reg) + k) % N_PORT);
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ret_beat_reg  <= '0;
            ret_valid_reg <= 1'b0;
            ret_src_reg   <= '0;
            last_reg      <= SRC_W'(N_PORT - 1);
        end else begin
            ret_valid_reg <= grant_valid;
            if (grant_valid) begin
                ret_beat_reg <= head[grant_idx];
                ret_src_reg  <= grant_idx;
                last_reg     <= grant_idx;
            end
        end
    end

    assign bus.ret_valid_o = ret_valid_reg;
    assign bus.ret_rdata_o = ret_beat_reg.rdata;
    assign bus.ret_id_o    = ret_beat_reg.id;
    assign bus.ret_user_o  = ret_beat_reg.user;
    assign bus.ret_error_o = ret_beat_reg.error;
    assign bus.ret_mmio_o  = ret_beat_reg.mmio;
    assign bus.ret_src_o   = ret_src_reg;

endmodule

// File: tb/tb_cache_return_arbiter.sv
// Self-checking bench: per-port queues and a rotating pointer predict every return beat and ready vector.
module tb_cache_return_arbiter;
    import prv664_cache_ret_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int SRC_W = 2;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    cache_return_arbiter_if #(.N_PORT(N)) bus ();

    cache_return_arbiter #(.N_PORT(N), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: queue contents per port, last winner, and the beat expected on the channel.
    cache_ret_beat_t mq [N][$];
    int              last_m;
    logic            exp_valid;
    cache_ret_beat_t exp_beat;
    int              exp_src;
    logic [N-1:0]    exp_ready;
    cache_ret_beat_t got_beat;

    assign got_beat = {bus.ret_rdata_o, bus.ret_id_o, bus.ret_user_o, bus.ret_error_o, bus.ret_mmio_o};

    always @(posedge clk) begin : model
        int win;
        int p;
        logic [N-1:0] rdy;
        if (srst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            last_m    = N - 1;
            exp_valid = 1'b0;
            exp_beat  = '0;
            exp_src   = 0;
        end else begin
            for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < DEPTH);
            win = -1;
            for (int k = 1; k <= N; k++) begin
                p = (last_m + k) % N;
                if (win < 0 && mq[p].size() > 0) win = p;
            end
            exp_valid = (win >= 0);
            if (win >= 0) begin
                exp_beat = mq[win].pop_front();
                exp_src  = win;
                last_m   = win;
            end
            for (int i = 0; i < N; i++)
                if (bus.src_valid_i[i] && rdy[i])
                    mq[i].push_back({bus.src_rdata_i[i], bus.src_id_i[i], bus.src_user_i[i],
                                     bus.src_error_i[i], bus.src_mmio_i[i]});
        end
        for (int i = 0; i < N; i++) exp_ready[i] = (mq[i].size() < DEPTH);
    end

    function automatic cache_ret_beat_t rand_beat(input logic [7:0] id);
        cache_ret_beat_t b;
        b.rdata = {$urandom, $urandom, $urandom, $urandom};
        b.id    = id;
        b.user  = CACHE_USER_W'($urandom);
        b.error = ERR_W'($urandom);
        b.mmio  = 1'($urandom);
        return b;
    endfunction

    task automatic set_beat(input int p, input cache_ret_beat_t b);
        bus.src_rdata_i[p] = b.rdata;
        bus.src_id_i[p]    = b.id;
        bus.src_user_i[p]  = b.user;
        bus.src_error_i[p] = b.error;
        bus.src_mmio_i[p]  = b.mmio;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        srst = 1'b1;
        bus.src_valid_i = '0;
        cycle();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        bus.src_valid_i = '1;
        for (int p = 0; p < N; p++) set_beat(p, rand_beat(8'hEE));
        cycle();
        cycle();
        tests_run++;
        if (bus.ret_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b expected 0", bus.ret_valid_o);
        end
        tests_run++;
        if (got_beat !== '0 || bus.ret_src_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_fields: got id=%h src=%0d expected all zero", bus.ret_id_o, bus.ret_src_o);
        end
        tests_run++;
        if (bus.src_ready_o !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_ready: got %h expected f", bus.src_ready_o);
        end
        srst = 1'b0;
        bus.src_valid_i = '0;
        cycle();
        tests_run++;
        if (bus.ret_valid_o !== 1'b0 || bus.src_ready_o !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_release: got valid=%b ready=%h expected 0/f", bus.ret_valid_o, bus.src_ready_o);
        end
    endtask

    task automatic test_single_port();
        cache_ret_beat_t b;
        int pulses = 0;
        int pulse_c = -1;
        apply_reset();
        b = '{rdata: {16{8'hA5}}, id: 8'h15, user: CACHE_USER_W'($urandom), error: '0, mmio: 1'b1};
        set_beat(2, b);
        bus.src_valid_i = 4'b0100;
        for (int c = 1; c <= 6; c++) begin
            cycle();
            bus.src_valid_i = '0;
            tests_run++;
            if (bus.ret_valid_o !== exp_valid) begin
                tests_failed++;
                $display("FAIL single_valid c%0d: got %b expected %b", c, bus.ret_valid_o, exp_valid);
            end
            if (bus.ret_valid_o) begin
                $display("[TB] single beat src=%0d id=%h", bus.ret_src_o, bus.ret_id_o);
                pulses++;
                pulse_c = c;
                tests_run++;
                if (got_beat !== b || bus.ret_src_o !== 2'd2) begin
                    tests_failed++;
                    $display("FAIL single_fields: got id=%h src=%0d expected id=15 src=2", bus.ret_id_o, bus.ret_src_o);
                end
            end
        end
        tests_run++;
        if (pulses != 1 || pulse_c != 2) begin
            tests_failed++;
            $display("FAIL single_timing: got %0d pulses at cycle %0d expected 1 at cycle 2", pulses, pulse_c);
        end
    endtask

    task automatic test_contend();
        int n;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < N; p++) set_beat(p, rand_beat(8'(16 * r + p)));
            bus.src_valid_i = '1;
            n = 0;
            for (int c = 0; c < 6; c++) begin
                cycle();
                bus.src_valid_i = '0;
                tests_run++;
                if (bus.ret_valid_o !== exp_valid || (exp_valid && got_beat !== exp_beat)) begin
                    tests_failed++;
                    $display("FAIL contend_model r%0d c%0d: got v=%b id=%h expected v=%b id=%h",
                             r, c, bus.ret_valid_o, bus.ret_id_o, exp_valid, exp_beat.id);
                end
                if (bus.ret_valid_o) begin
                    $display("[TB] contend beat src=%0d id=%h", bus.ret_src_o, bus.ret_id_o);
                    tests_run++;
                    if (bus.ret_src_o !== SRC_W'(n) || c != n + 1) begin
                        tests_failed++;
                        $display("FAIL contend_order r%0d: got src=%0d at c%0d expected src=%0d at c%0d",
                                 r, bus.ret_src_o, c, n, n + 1);
                    end
                    n++;
                end
            end
            tests_run++;
            if (n != N) begin
                tests_failed++;
                $display("FAIL contend_count r%0d: got %0d beats expected %0d", r, n, N);
            end
        end
    endtask

    task automatic test_backpressure();
        int seq [N];
        logic [N-1:0] acc;
        int acc1 = 0;
        int acc_at_drop = -1;
        int n_out = 0;
        int p1 = 0;
        apply_reset();
        for (int p = 0; p < N; p++) begin
            seq[p] = 0;
            set_beat(p, rand_beat({2'(p), 6'd0}));
        end
        bus.src_valid_i = '1;
        for (int c = 0; c < 40; c++) begin
            if (acc_at_drop < 0 && !bus.src_ready_o[1]) acc_at_drop = acc1;
            acc = bus.src_valid_i & bus.src_ready_o;
            if (acc[1]) acc1++;
            cycle();
            tests_run++;
            if (bus.ret_valid_o !== exp_valid || (exp_valid && (got_beat !== exp_beat || bus.ret_src_o !== SRC_W'(exp_src)))) begin
                tests_failed++;
                $display("FAIL bp_model c%0d: got v=%b src=%0d id=%h expected v=%b src=%0d id=%h",
                         c, bus.ret_valid_o, bus.ret_src_o, bus.ret_id_o, exp_valid, exp_src, exp_beat.id);
            end
            tests_run++;
            if (bus.src_ready_o !== exp_ready) begin
                tests_failed++;
                $display("FAIL bp_ready c%0d: got %b expected %b", c, bus.src_ready_o, exp_ready);
            end
            if (bus.ret_valid_o) $display("[TB] bp beat src=%0d id=%h", bus.ret_src_o, bus.ret_id_o);
            if (c >= 8 && bus.ret_valid_o) begin
                n_out++;
                if (bus.ret_src_o == 2'd1) p1++;
            end
            for (int p = 0; p < N; p++)
                if (acc[p]) begin
                    seq[p]++;
                    set_beat(p, rand_beat({2'(p), 6'(seq[p])}));
                end
        end
        bus.src_valid_i = '0;
        tests_run++;
        if (acc_at_drop != 2) begin
            tests_failed++;
            $display("FAIL bp_ready_drop: got drop after %0d accepts expected 2", acc_at_drop);
        end
        tests_run++;
        if (n_out != 32 || p1 != 8) begin
            tests_failed++;
            $display("FAIL bp_fairness: got %0d beats with %0d from port1 expected 32 with 8", n_out, p1);
        end
    endtask

    task automatic test_push_pop();
        int nxt_id = 0;
        int exp_id = 0;
        int first_c = -1;
        int last_c = -1;
        logic acc0;
        apply_reset();
        set_beat(0, rand_beat(8'd0));
        bus.src_valid_i = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            acc0 = bus.src_valid_i[0] & bus.src_ready_o[0];
            cycle();
            tests_run++;
            if (bus.ret_valid_o !== exp_valid || bus.src_ready_o !== exp_ready) begin
                tests_failed++;
                $display("FAIL stream_model c%0d: got v=%b rdy=%b expected v=%b rdy=%b",
                         c, bus.ret_valid_o, bus.src_ready_o, exp_valid, exp_ready);
            end
            if (bus.ret_valid_o) begin
                $display("[TB] stream beat src=%0d id=%h", bus.ret_src_o, bus.ret_id_o);
                tests_run++;
                if (bus.ret_id_o !== 8'(exp_id) || got_beat !== exp_beat) begin
                    tests_failed++;
                    $display("FAIL stream_order: got id=%h expected id=%h", bus.ret_id_o, 8'(exp_id));
                end
                exp_id++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (acc0) begin
                nxt_id++;
                if (nxt_id == 32) bus.src_valid_i = '0;
                else set_beat(0, rand_beat(8'(nxt_id)));
            end
        end
        tests_run++;
        if (exp_id != 32 || last_c - first_c != 31) begin
            tests_failed++;
            $display("FAIL stream_rate: got %0d beats over %0d cycles expected 32 over 32",
                     exp_id, last_c - first_c + 1);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int src_seen [2];
        apply_reset();
        for (int p = 0; p < N; p++) set_beat(p, rand_beat(8'(8'h40 + p)));
        bus.src_valid_i = '1;
        cycle();
        for (int p = 0; p < N; p++) set_beat(p, rand_beat(8'(8'h50 + p)));
        cycle();
        srst = 1'b1;
        bus.src_valid_i = 4'b1000;
        set_beat(3, rand_beat(8'h66));
        cycle();
        srst = 1'b0;
        bus.src_valid_i = '0;
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (bus.ret_valid_o !== 1'b0 || bus.src_ready_o !== 4'hF || exp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL midreset_quiet c%0d: got v=%b rdy=%h expected v=0 rdy=f", c, bus.ret_valid_o, bus.src_ready_o);
            end
            cycle();
        end
        set_beat(0, rand_beat(8'h70));
        set_beat(3, rand_beat(8'h73));
        bus.src_valid_i = 4'b1001;
        src_seen[0] = -1;
        src_seen[1] = -1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            bus.src_valid_i = '0;
            tests_run++;
            if (bus.ret_valid_o !== exp_valid || (exp_valid && got_beat !== exp_beat)) begin
                tests_failed++;
                $display("FAIL midreset_model c%0d: got v=%b id=%h expected v=%b id=%h",
                         c, bus.ret_valid_o, bus.ret_id_o, exp_valid, exp_beat.id);
            end
            if (bus.ret_valid_o) begin
                $display("[TB] midreset beat src=%0d id=%h", bus.ret_src_o, bus.ret_id_o);
                if (n < 2) src_seen[n] = int'(bus.ret_src_o);
                n++;
            end
        end
        tests_run++;
        if (n != 2 || src_seen[0] != 0 || src_seen[1] != 3) begin
            tests_failed++;
            $display("FAIL midreset_priority: got %0d beats srcs %0d,%0d expected 2 beats srcs 0,3",
                     n, src_seen[0], src_seen[1]);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < N; p++) set_beat(p, rand_beat({2'(p), 6'($urandom)}));
            bus.src_valid_i = N'($urandom);
            cycle();
            tests_run++;
            if (bus.ret_valid_o !== exp_valid || (exp_valid && (got_beat !== exp_beat || bus.ret_src_o !== SRC_W'(exp_src)))) begin
                tests_failed++;
                $display("FAIL random_model c%0d: got v=%b src=%0d id=%h expected v=%b src=%0d id=%h",
                         c, bus.ret_valid_o, bus.ret_src_o, bus.ret_id_o, exp_valid, exp_src, exp_beat.id);
            end
            tests_run++;
            if (bus.src_ready_o !== exp_ready) begin
                tests_failed++;
                $display("FAIL random_ready c%0d: got %b expected %b", c, bus.src_ready_o, exp_ready);
            end
        end
        bus.src_valid_i = '0;
    endtask

    initial begin
        srst = 1'b1;
        bus.src_valid_i = '0;
        for (int p = 0; p < N; p++) set_beat(p, '0);
        @(negedge clk);
        test_reset();
        test_single_port();
        test_contend();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
